// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I opcodes, interlock FSM encoding and small helpers
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } hz_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - outstanding-load destination mask with WB-bypassed read ports
module load_scoreboard
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [31:0] pending
);

  logic [31:0] pend_q;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] visible;

  // Readers see the mask after this cycle's WB clear; the new set is not visible
  // to its own producer, which also keeps the set path free of a loop through stall_id.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    if (set_en) set_mask[set_idx] = 1'b1;
    visible = pend_q & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (!freeze) begin
      pend_q <= (visible | set_mask) & 32'hFFFF_FFFE;
    end
  end

  assign rs1_busy = visible[rs1];
  assign rs2_busy = visible[rs2];
  assign pending  = pend_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I pipeline interlock: load-use stalls, branch flush, memory freeze, watchdog
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MAX_MEM_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_wr_reg_n,
  input  logic        id_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        halted,
  output logic [31:0] pending
);

  localparam logic [7:0] MAX_W = 8'(MAX_MEM_WAIT);

  hz_state_t  state, state_d;
  logic [7:0] wait_cnt, wait_d;
  logic       rs1_busy, rs2_busy;
  logic       raw, mem_block, in_halt, load_issue;

  assign in_halt    = (state == ST_HALT);
  assign mem_block  = mem_req & ~mem_ack;
  assign raw        = id_valid & ((id_uses_rs1 & rs1_busy) | (id_uses_rs2 & rs2_busy));
  assign load_issue = id_valid & id_is_load & ~id_wr_reg_n & ~stall_id & ~flush_id;

  load_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .freeze   (in_halt),
    .set_en   (load_issue),
    .set_idx  (id_rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .pending  (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
    end
  end

  // wait_cnt counts consecutive un-acked cycles, including the RUN cycle that started the wait.
  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    case (state)
      ST_RUN: begin
        if (mem_block) begin
          wait_d  = 8'd1;
          state_d = (MAX_W <= 8'd1) ? ST_HALT : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_req || mem_ack) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          wait_d = sat_inc8(wait_cnt);
          if (wait_d >= MAX_W) state_d = ST_HALT;
        end
      end
      ST_HALT: ;
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, whatever the live inputs are.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    halted    = 1'b0;
    if (rst_n) begin
      if (in_halt || mem_block) begin
        halted    = in_halt;
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (ex_branch_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (raw) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with a behavioural interlock model
module tb_hazard_ctrl;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_wr_reg_n, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        ex_branch_taken, mem_req, mem_ack, wb_valid;
  logic        stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id, halted;
  logic [31:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pend;
  int          m_unacked;
  bit          m_halt;

  hazard_ctrl #(.MAX_MEM_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_wr_reg_n(id_wr_reg_n), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .halted(halted), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit src_busy(input logic [4:0] r);
    return m_pend[r] && !(wb_valid && wb_rd == r);
  endfunction

  // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id, halted}
  function automatic logic [6:0] model_ctl();
    bit hazard;
    if (!rst_n) return 7'b0;
    if (m_halt) return 7'b1111_001;
    if (mem_req && !mem_ack) return 7'b1111_000;
    if (ex_branch_taken) return 7'b0000_110;
    hazard = id_valid && ((id_uses_rs1 && src_busy(id_rs1)) || (id_uses_rs2 && src_busy(id_rs2)));
    return hazard ? 7'b1100_100 : 7'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [6:0]  e;
    logic [31:0] np;
    int          nu;
    if (!rst_n) begin
      m_pend    <= '0;
      m_unacked <= 0;
      m_halt    <= 1'b0;
    end else if (!m_halt) begin
      e  = model_ctl();
      np = m_pend;
      if (wb_valid) np[wb_rd] = 1'b0;
      if (id_valid && id_is_load && !id_wr_reg_n && !e[5] && !e[1] && id_rd != 5'd0)
        np[id_rd] = 1'b1;
      m_pend <= np;
      nu = (mem_req && !mem_ack) ? m_unacked + 1 : 0;
      m_unacked <= nu;
      if (nu >= MAXW) m_halt <= 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [6:0] e;
    e = model_ctl();
    chk("stall_if",  {31'b0, stall_if},  {31'b0, e[6]});
    chk("stall_id",  {31'b0, stall_id},  {31'b0, e[5]});
    chk("stall_ex",  {31'b0, stall_ex},  {31'b0, e[4]});
    chk("stall_mem", {31'b0, stall_mem}, {31'b0, e[3]});
    chk("bubble_ex", {31'b0, bubble_ex}, {31'b0, e[2]});
    chk("flush_id",  {31'b0, flush_id},  {31'b0, e[1]});
    chk("halted",    {31'b0, halted},    {31'b0, e[0]});
    chk("pending",   pending, rst_n ? m_pend : 32'h0);
  end

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_wr_reg_n = 1; id_is_load = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ack = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id_load(input logic [4:0] rd, input logic wr_n);
    id_valid = 1; id_is_load = 1; id_rd = rd; id_wr_reg_n = wr_n;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    mem_req = 1;
    #2;
    chk("reset_stall_if", {31'b0, stall_if}, 32'h0);
    chk("reset_pending", pending, 32'h0);
    cyc();
    idle();
    rst_n = 1;
    cyc();

    // load x5 then add x6,x5,x1: stall until WB of x5, issue in that cycle
    id_load(5'd5, 1'b0);
    #2 chk("lu_first_nostall", {31'b0, stall_id}, 32'h0);
    cyc();
    chk("lu_pending5", pending, 32'h0000_0020);
    idle();
    id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 1; id_uses_rs2 = 1; id_rd = 6; id_wr_reg_n = 0;
    #2 chk("lu_stall_c1", {31'b0, stall_id}, 32'h1);
    chk("lu_bubble_c1", {31'b0, bubble_ex}, 32'h1);
    cyc();
    #2 chk("lu_stall_c2", {31'b0, stall_if}, 32'h1);
    cyc();
    wb_valid = 1; wb_rd = 5;
    #2 chk("lu_bypass_issue", {31'b0, stall_id}, 32'h0);
    cyc();
    chk("lu_pending_clear", pending, 32'h0);
    idle();

    // load to x0 never marks pending
    id_load(5'd0, 1'b1);
    cyc();
    chk("x0_pending", pending, 32'h0);
    idle();
    id_valid = 1; id_rs1 = 0; id_uses_rs1 = 1;
    #2 chk("x0_nostall", {31'b0, stall_id}, 32'h0);
    cyc();
    idle();

    // branch overrides hazard; flushed load x9 does not set pending
    id_load(5'd7, 1'b0);
    cyc();
    id_load(5'd9, 1'b0);
    id_rs1 = 7; id_uses_rs1 = 1; ex_branch_taken = 1;
    #2 chk("br_flush", {31'b0, flush_id}, 32'h1);
    chk("br_bubble", {31'b0, bubble_ex}, 32'h1);
    chk("br_stall_id", {31'b0, stall_id}, 32'h0);
    cyc();
    chk("br_pending", pending, 32'h0000_0080);
    idle();
    wb_valid = 1; wb_rd = 7;
    cyc();
    idle();

    // same-cycle set and clear of x8: set wins
    id_load(5'd8, 1'b0);
    cyc();
    id_load(5'd8, 1'b0);
    wb_valid = 1; wb_rd = 8;
    cyc();
    chk("setclr_pending", pending, 32'h0000_0100);
    idle();
    wb_valid = 1; wb_rd = 8;
    cyc();
    chk("setclr_clear", pending, 32'h0);
    idle();

    // memory wait of 3 cycles with a branch held during the freeze
    mem_req = 1;
    #2 chk("mw_stall_mem", {31'b0, stall_mem}, 32'h1);
    cyc();
    chk("mw_state", {30'b0, dut.state}, 32'h1);
    ex_branch_taken = 1;
    #2 chk("mw_no_flush", {31'b0, flush_id}, 32'h0);
    cyc();
    cyc();
    mem_ack = 1;
    #2 chk("mw_ack_flush", {31'b0, flush_id}, 32'h1);
    chk("mw_ack_nostall", {31'b0, stall_if}, 32'h0);
    cyc();
    chk("mw_back_run", {30'b0, dut.state}, 32'h0);
    idle();
    cyc();

    // watchdog: no ack for MAXW cycles halts; reset releases immediately
    mem_req = 1;
    #2 chk("wd_not_yet0", {31'b0, halted}, 32'h0);
    cyc(); cyc(); cyc();
    chk("wd_not_yet3", {31'b0, halted}, 32'h0);
    cyc();
    chk("wd_halted", {31'b0, halted}, 32'h1);
    mem_req = 0;
    id_load(5'd3, 1'b0);
    cyc(); cyc();
    chk("wd_sticky", {31'b0, halted}, 32'h1);
    chk("wd_stall_held", {31'b0, stall_if}, 32'h1);
    chk("wd_sb_frozen", pending, 32'h0);
    #2 rst_n = 0;
    #1 chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_stall_id", {31'b0, stall_id}, 32'h0);
    cyc();
    idle();
    rst_n = 1;
    cyc();
    chk("rst_state_run", {30'b0, dut.state}, 32'h0);
    chk("rst_no_halt", {31'b0, halted}, 32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock controller for the five-stage RV32I core. It takes the decoded register fields and write-enable from the ID stage, the branch-resolution signal from EX, the data-memory handshake from MEM and the write-back port. From these it generates per-stage stall, bubble and flush controls. It keeps a scoreboard of outstanding load destinations, a memory-wait state machine and a timeout watchdog.

## Interface
- MAX_MEM_WAIT, 15: consecutive un-acked memory cycles tolerated before halting (1..255).
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  5  source register indices from ID
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads that source
- id_rd  in  5  destination index from ID
- id_wr_reg_n  in  1  0: instruction writes rd, 1: no write (already 1 for rd==x0)
- id_is_load  in  1  ID instruction is a load (opcode 0000011)
- ex_branch_taken  in  1  EX redirects the PC this cycle (taken branch, JAL, JALR)
- mem_req  in  1  MEM stage issues a data access
- mem_ack  in  1  data memory completes the access this cycle
- wb_valid  in  1  WB writes the register file this cycle
- wb_rd  in  5  WB destination index
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the stage register
- bubble_ex  out  1  load a NOP into the ID/EX register
- flush_id  out  1  replace the IF/ID content with a NOP
- halted  out  1  watchdog tripped (sticky)
- pending  out  32  scoreboard bits (bit 0 always 0)

## Operation
- Scoreboard: `pending[r]` set on load issue: `id_valid & id_is_load & !id_wr_reg_n & !stall_id & !flush_id`, with r = `id_rd`. Cleared when `wb_valid & wb_rd==r`.
- If the same r is set and cleared in one cycle, the set wins. x0 is never set.
- Raw hazard (combinational): `id_valid` and (`id_uses_rs1 & pending[id_rs1]` or `id_uses_rs2 & pending[id_rs2]`). The register file has a write-through bypass, so a WB clear in the same cycle removes the hazard (use the next-state mask).
- Hazard response: stall_if=1, stall_id=1, bubble_ex=1.
- Branch: `ex_branch_taken` gives flush_id=1 and bubble_ex=1. Flush overrides a raw hazard; stall_if and stall_id are deasserted, because the ID instruction is wrong-path.
- Memory freeze: `mem_req & !mem_ack` asserts all four stalls. bubble_ex=0 and flush_id=0 while frozen; a pending branch or hazard is re-evaluated after the freeze.
- Priority, highest first: halted > memory freeze > branch flush > raw hazard.
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.
  - RUN goes to MEM_WAIT when `mem_req & !mem_ack`, and loads wait_cnt=1.
  - MEM_WAIT goes to RUN on `mem_ack`. On `!mem_ack`, wait_cnt increments. When wait_cnt reaches MAX_MEM_WAIT with no ack, the FSM goes to HALT.
  - MEM_WAIT returns to RUN if `mem_req` drops (aborted access).
  - HALT is held until reset. All stalls are 1, halted=1, flush_id=0 and bubble_ex=0. The scoreboard is frozen.
- Reset (asynchronous): pending=0, state=RUN, wait_cnt=0. All outputs read 0 while rst_n is low. Reset mid-stall or mid-halt releases everything immediately.

## Timing
- All stall, bubble and flush outputs are combinational from the inputs and registered state, so they are valid in the same cycle.
- The scoreboard and FSM update on the rising edge of clk.
- Load-use latency: a load in ID at cycle t sets pending at t+1. A dependent instruction stalls from t+1 until the cycle the load's WB occurs (inclusive of the bypass, so it issues in that cycle).
- Memory freeze begins in the same cycle as `mem_req & !mem_ack` and ends in the ack cycle.
- HALT is entered on the edge after the MAX_MEM_WAIT-th un-acked cycle.
- wait_cnt is 8-bit and saturates; there is no wrap.

## Structure
- Shared `core_pkg` holds: opcode constants (load 0000011 and others, shared with decode) and the FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2).
- One natural sub-module: `load_scoreboard` (32-bit set/clear mask plus the two read ports with bypass).
- FSM and watchdog stay in `hazard_ctrl`.

## Test plan
- Load-use: load x5, then `add x6,x5,x1`. pending[5]=1, with a stall of exactly the cycles until wb_rd=5, then issue. pending returns to 0.
- Load to x0 (id_wr_reg_n=1): pending stays 0, with no stall on a following reader of x0.
- Branch during hazard: raw hazard and ex_branch_taken together give flush_id=1, bubble_ex=1, stall_id=0. The flushed load does not set pending.
- Memory wait: mem_req=1, ack after 3 cycles gives all stalls=1 for 3 cycles, state MEM_WAIT, then RUN. A branch asserted during the freeze is flushed only after the ack.
- Watchdog (MAX_MEM_WAIT=4): no ack gives halted=1 after 4 wait cycles, with stalls held indefinitely. Asserting rst_n=0 gives all outputs 0 immediately.
- Set and clear of the same rd in one cycle: pending[rd] remains 1.
